// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
// Used by the APB requester (apb_master) and the APB completer.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;

    // APB transfer phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB transfer
// (IDLE -> SETUP -> ACCESS) and returns a single-cycle completion pulse.
// An optional wait-state limit aborts transfers whose completer never
// raises PREADY.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_write/addr/wdata   command payload
//   rsp_valid              one-cycle completion pulse, never back-pressured
//   rsp_rdata              read data (0 for writes and aborts)
//   rsp_err, rsp_tmo       PSLVERR-or-timeout, timeout abort
//   PSEL..PWDATA           APB requester outputs
//   PRDATA, PREADY, PSLVERR APB completer inputs
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_tmo,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TMO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e state_q, state_d;

    // The APB address/direction/data registers double as the captured
    // command: they load on acceptance and hold until the next acceptance.
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,  paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_tmo_q,   rsp_tmo_d;
    logic [CNT_W-1:0]      wait_q,      wait_d;

    logic                  timeout_hit_c;

    // Last permitted wait cycle reached with PREADY still low
    assign timeout_hit_c = TMO_EN && (wait_q == WAIT_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_tmo_d   = 1'b0;
        wait_d      = wait_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = ST_SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    psel_d   = 1'b1;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                wait_d    = '0;
            end

            ST_ACCESS: begin
                // PREADY takes priority over a timeout firing in the same cycle
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (timeout_hit_c) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    wait_d    = wait_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            wait_q      <= wait_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule : apb_master
